// File: rtl/fifo_alloc_valid_tracker.sv
// ----------------------------------------------------------------------------
// fifo_alloc_valid_tracker
//   Bookkeeping core for a reorder FIFO with variable-size allocation and
//   in-order retirement. Holds circular write/read pointers, used/free counts
//   and one "written" flag per slot. Data lives in a neighbouring 1R1W memory.
// ----------------------------------------------------------------------------

module fifo_alloc_valid_tracker_chk #(
    parameter int els_p            = 8,
    parameter int enq_amount_max_p = els_p,
    parameter int deq_amount_max_p = 1,
    parameter int cnt_w_p          = 4,
    parameter int enq_w_p          = 4,
    parameter int deq_w_p          = 1
) (
    input logic               clk_i,
    input logic               reset_n_i,
    input logic [enq_w_p-1:0] enq_amount_i,
    input logic [deq_w_p-1:0] deq_amount_i,
    input logic [cnt_w_p-1:0] free_entries_r_i,
    input logic [cnt_w_p-1:0] used_entries_r_i
);

    // Slot indexing relies on natural pointer truncation.
    if ((els_p < 2) || ((els_p & (els_p - 1)) != 0)) begin : g_bad_els
        $error("fifo_alloc_valid_tracker: els_p must be a power of two >= 2");
    end

    // Caller errors, sampled away from the active edge. Slots retired in the
    // same cycle are handed back before the allocation lands, so an
    // allocation may consume them (full-to-full exchange).
    always @(negedge clk_i) begin
        if (reset_n_i) begin
            if (32'(enq_amount_i) > (32'(free_entries_r_i) + 32'(deq_amount_i))) begin
                $error("fifo_alloc_valid_tracker: over-allocation enq=%0d free=%0d",
                       enq_amount_i, free_entries_r_i);
            end
            if (32'(deq_amount_i) > 32'(used_entries_r_i)) begin
                $error("fifo_alloc_valid_tracker: over-retirement deq=%0d used=%0d",
                       deq_amount_i, used_entries_r_i);
            end
        end
    end

endmodule

module fifo_alloc_valid_tracker #(
    parameter int els_p            = 8,
    parameter int enq_amount_max_p = els_p,
    parameter int deq_amount_max_p = 1,
    parameter int clear_over_set_p = 0,
    localparam int lg_els_lp       = $clog2(els_p),
    localparam int cnt_w_lp        = $clog2(els_p + 1),
    localparam int enq_w_lp        = $clog2(enq_amount_max_p + 1),
    localparam int deq_w_lp        = $clog2(deq_amount_max_p + 1)
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic [enq_w_lp-1:0]  enq_amount_i,
    input  logic [deq_w_lp-1:0]  deq_amount_i,
    input  logic                 set_v_i,
    input  logic [lg_els_lp-1:0] set_id_i,
    output logic [lg_els_lp-1:0] wptr_r_o,
    output logic [lg_els_lp-1:0] rptr_r_o,
    output logic [lg_els_lp-1:0] rptr_n_o,
    output logic [cnt_w_lp-1:0]  free_entries_r_o,
    output logic [cnt_w_lp-1:0]  used_entries_r_o,
    output logic [els_p-1:0]     valid_r_o,
    output logic                 head_v_o,
    output logic                 empty_o,
    output logic                 full_o
);

    // One-hot slot select for the random-access write; all zeros when idle.
    function automatic logic [els_p-1:0] set_decode(
        input logic                 v,
        input logic [lg_els_lp-1:0] id
    );
        logic [els_p-1:0] mask;
        mask     = {els_p{1'b0}};
        mask[id] = v;
        return mask;
    endfunction

    // Circular run of slots base..base+amt-1 being retired this cycle.
    function automatic logic [els_p-1:0] retire_mask(
        input logic [lg_els_lp-1:0] base,
        input logic [deq_w_lp-1:0]  amt
    );
        logic [els_p-1:0]     mask;
        logic [lg_els_lp-1:0] idx;
        mask = {els_p{1'b0}};
        for (int i = 0; i < deq_amount_max_p; i++) begin
            idx       = lg_els_lp'(32'(base) + 32'(i));
            mask[idx] = mask[idx] | (32'(i) < 32'(amt));
        end
        return mask;
    endfunction

    logic [lg_els_lp-1:0] wptr_r;
    logic [lg_els_lp-1:0] rptr_r;
    logic [cnt_w_lp-1:0]  used_r;
    logic [cnt_w_lp-1:0]  free_r;
    logic [els_p-1:0]     valid_r;
    logic                 head_v_r;
    logic                 empty_r;
    logic                 full_r;

    logic [lg_els_lp-1:0] wptr_next_s;
    logic [lg_els_lp-1:0] rptr_next_s;
    logic [cnt_w_lp-1:0]  used_next_s;
    logic [cnt_w_lp-1:0]  free_next_s;
    logic [els_p-1:0]     set_s;
    logic [els_p-1:0]     clr_s;
    logic [els_p-1:0]     valid_next_s;

    // Next pointers and counts; pointer wrap is plain truncation.
    always_comb begin
        wptr_next_s = lg_els_lp'(32'(wptr_r) + 32'(enq_amount_i));
        rptr_next_s = lg_els_lp'(32'(rptr_r) + 32'(deq_amount_i));
        used_next_s = cnt_w_lp'(32'(used_r) + 32'(enq_amount_i) - 32'(deq_amount_i));
        free_next_s = cnt_w_lp'(32'(els_p) - 32'(used_next_s));
    end

    // Next valid vector; the collision policy decides set versus clear.
    always_comb begin
        set_s = set_decode(set_v_i, set_id_i);
        clr_s = retire_mask(rptr_r, deq_amount_i);
        if (clear_over_set_p != 0) begin
            valid_next_s = (valid_r | set_s) & ~clr_s;
        end else begin
            valid_next_s = (valid_r & ~clr_s) | set_s;
        end
    end

    // State registers; head/empty/full are registered from next-state values
    // so they stay in step with the pointers and counts.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r   <= {lg_els_lp{1'b0}};
            rptr_r   <= {lg_els_lp{1'b0}};
            used_r   <= {cnt_w_lp{1'b0}};
            free_r   <= cnt_w_lp'(els_p);
            valid_r  <= {els_p{1'b0}};
            head_v_r <= 1'b0;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else begin
            wptr_r   <= wptr_next_s;
            rptr_r   <= rptr_next_s;
            used_r   <= used_next_s;
            free_r   <= free_next_s;
            valid_r  <= valid_next_s;
            head_v_r <= valid_next_s[rptr_next_s];
            empty_r  <= (used_next_s == {cnt_w_lp{1'b0}});
            full_r   <= (free_next_s == {cnt_w_lp{1'b0}});
        end
    end

    assign wptr_r_o         = wptr_r;
    assign rptr_r_o         = rptr_r;
    assign rptr_n_o         = rptr_next_s;
    assign free_entries_r_o = free_r;
    assign used_entries_r_o = used_r;
    assign valid_r_o        = valid_r;
    assign head_v_o         = head_v_r;
    assign empty_o          = empty_r;
    assign full_o           = full_r;

`ifndef SYNTHESIS
    fifo_alloc_valid_tracker_chk #(
        .els_p            (els_p),
        .enq_amount_max_p (enq_amount_max_p),
        .deq_amount_max_p (deq_amount_max_p),
        .cnt_w_p          (cnt_w_lp),
        .enq_w_p          (enq_w_lp),
        .deq_w_p          (deq_w_lp)
    ) u_chk (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .enq_amount_i     (enq_amount_i),
        .deq_amount_i     (deq_amount_i),
        .free_entries_r_i (free_r),
        .used_entries_r_i (used_r)
    );
`endif

endmodule

// File: tb/tb_fifo_alloc_valid_tracker.sv
// ----------------------------------------------------------------------------
// Directed bench for fifo_alloc_valid_tracker (els_p=8, enq max 8, deq max 1).
// ----------------------------------------------------------------------------
module tb_fifo_alloc_valid_tracker;

    logic       clk_i;
    logic       reset_n_i;
    logic [3:0] enq_amount_i;
    logic [0:0] deq_amount_i;
    logic       set_v_i;
    logic [2:0] set_id_i;
    logic [2:0] wptr_r_o;
    logic [2:0] rptr_r_o;
    logic [2:0] rptr_n_o;
    logic [3:0] free_entries_r_o;
    logic [3:0] used_entries_r_o;
    logic [7:0] valid_r_o;
    logic       head_v_o;
    logic       empty_o;
    logic       full_o;

    int n_cmp  = 0;
    int n_fail = 0;

    fifo_alloc_valid_tracker dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .enq_amount_i     (enq_amount_i),
        .deq_amount_i     (deq_amount_i),
        .set_v_i          (set_v_i),
        .set_id_i         (set_id_i),
        .wptr_r_o         (wptr_r_o),
        .rptr_r_o         (rptr_r_o),
        .rptr_n_o         (rptr_n_o),
        .free_entries_r_o (free_entries_r_o),
        .used_entries_r_o (used_entries_r_o),
        .valid_r_o        (valid_r_o),
        .head_v_o         (head_v_o),
        .empty_o          (empty_o),
        .full_o           (full_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0; enq_amount_i = 4'd0; deq_amount_i = 1'b0;
        set_v_i = 1'b0; set_id_i = 3'd0;
        repeat (2) @(posedge clk_i);
        #1 reset_n_i = 1'b1;
        tick();
        n_cmp++; if (wptr_r_o !== 3'd0) begin n_fail++; $display("FAIL reset_wptr got %0d want 0", wptr_r_o); end
        n_cmp++; if (rptr_r_o !== 3'd0) begin n_fail++; $display("FAIL reset_rptr got %0d want 0", rptr_r_o); end
        n_cmp++; if (free_entries_r_o !== 4'd8) begin n_fail++; $display("FAIL reset_free got %0d want 8", free_entries_r_o); end
        n_cmp++; if (used_entries_r_o !== 4'd0) begin n_fail++; $display("FAIL reset_used got %0d want 0", used_entries_r_o); end
        n_cmp++; if ({empty_o, full_o, head_v_o} !== 3'b100) begin n_fail++; $display("FAIL reset_flags got %b want 100", {empty_o, full_o, head_v_o}); end
        n_cmp++; if (valid_r_o !== 8'h00) begin n_fail++; $display("FAIL reset_valid got %h want 00", valid_r_o); end
    endtask

    task automatic test_alloc_wrap();
        enq_amount_i = 4'd3;
        tick();
        n_cmp++; if (wptr_r_o !== 3'd3) begin n_fail++; $display("FAIL alloc3_wptr got %0d want 3", wptr_r_o); end
        n_cmp++; if (used_entries_r_o !== 4'd3 || free_entries_r_o !== 4'd5) begin n_fail++; $display("FAIL alloc3_counts got %0d/%0d want 3/5", used_entries_r_o, free_entries_r_o); end
        enq_amount_i = 4'd5;
        tick();
        enq_amount_i = 4'd0;
        n_cmp++; if (wptr_r_o !== 3'd0) begin n_fail++; $display("FAIL alloc5_wptr got %0d want 0", wptr_r_o); end
        n_cmp++; if (used_entries_r_o !== 4'd8 || free_entries_r_o !== 4'd0) begin n_fail++; $display("FAIL alloc5_counts got %0d/%0d want 8/0", used_entries_r_o, free_entries_r_o); end
        n_cmp++; if ({empty_o, full_o} !== 2'b01) begin n_fail++; $display("FAIL alloc5_flags got %b want 01", {empty_o, full_o}); end
    endtask

    task automatic test_full_swap();
        set_v_i = 1'b1; set_id_i = 3'd0;
        tick();
        set_v_i = 1'b0;
        n_cmp++; if (valid_r_o !== 8'h01 || head_v_o !== 1'b1) begin n_fail++; $display("FAIL swap_set0 got %h/%b want 01/1", valid_r_o, head_v_o); end
        deq_amount_i = 1'b1; enq_amount_i = 4'd1;
        #1;
        n_cmp++; if (rptr_n_o !== 3'd1) begin n_fail++; $display("FAIL swap_rptr_n got %0d want 1", rptr_n_o); end
        tick();
        deq_amount_i = 1'b0; enq_amount_i = 4'd0;
        n_cmp++; if (used_entries_r_o !== 4'd8 || full_o !== 1'b1) begin n_fail++; $display("FAIL swap_used got %0d/%b want 8/1", used_entries_r_o, full_o); end
        n_cmp++; if (rptr_r_o !== 3'd1 || wptr_r_o !== 3'd1) begin n_fail++; $display("FAIL swap_ptrs got r%0d w%0d want r1 w1", rptr_r_o, wptr_r_o); end
        n_cmp++; if (valid_r_o !== 8'h00 || head_v_o !== 1'b0) begin n_fail++; $display("FAIL swap_valid got %h/%b want 00/0", valid_r_o, head_v_o); end
    endtask

    task automatic test_collision();
        deq_amount_i = 1'b1;
        repeat (4) tick();
        n_cmp++; if (rptr_r_o !== 3'd5 || used_entries_r_o !== 4'd4) begin n_fail++; $display("FAIL coll_pre got r%0d u%0d want r5 u4", rptr_r_o, used_entries_r_o); end
        set_v_i = 1'b1; set_id_i = 3'd5;
        tick();
        set_v_i = 1'b0; deq_amount_i = 1'b0;
        n_cmp++; if (valid_r_o !== 8'h20) begin n_fail++; $display("FAIL coll_valid got %h want 20", valid_r_o); end
        n_cmp++; if (rptr_r_o !== 3'd6 || used_entries_r_o !== 4'd3 || head_v_o !== 1'b0) begin n_fail++; $display("FAIL coll_post got r%0d u%0d h%b want r6 u3 h0", rptr_r_o, used_entries_r_o, head_v_o); end
    endtask

    task automatic test_out_of_order();
        reset_n_i = 1'b0;
        #1 reset_n_i = 1'b1;
        enq_amount_i = 4'd3;
        tick();
        enq_amount_i = 4'd0;
        set_v_i = 1'b1; set_id_i = 3'd2;
        tick();
        n_cmp++; if (valid_r_o !== 8'h04 || head_v_o !== 1'b0) begin n_fail++; $display("FAIL ooo_id2 got %h/%b want 04/0", valid_r_o, head_v_o); end
        set_id_i = 3'd1;
        tick();
        n_cmp++; if (valid_r_o !== 8'h06 || head_v_o !== 1'b0) begin n_fail++; $display("FAIL ooo_id1 got %h/%b want 06/0", valid_r_o, head_v_o); end
        set_id_i = 3'd0;
        tick();
        set_v_i = 1'b0;
        n_cmp++; if (valid_r_o !== 8'h07 || head_v_o !== 1'b1) begin n_fail++; $display("FAIL ooo_id0 got %h/%b want 07/1", valid_r_o, head_v_o); end
        deq_amount_i = 1'b1;
        tick();
        n_cmp++; if (rptr_r_o !== 3'd1 || valid_r_o !== 8'h06 || head_v_o !== 1'b1) begin n_fail++; $display("FAIL ooo_deq1 got r%0d %h h%b want r1 06 h1", rptr_r_o, valid_r_o, head_v_o); end
        repeat (2) tick();
        deq_amount_i = 1'b0;
        n_cmp++; if (rptr_r_o !== 3'd3 || valid_r_o !== 8'h00 || head_v_o !== 1'b0) begin n_fail++; $display("FAIL ooo_deq3 got r%0d %h h%b want r3 00 h0", rptr_r_o, valid_r_o, head_v_o); end
        n_cmp++; if (used_entries_r_o !== 4'd0 || empty_o !== 1'b1) begin n_fail++; $display("FAIL ooo_empty got u%0d e%b want u0 e1", used_entries_r_o, empty_o); end
    endtask

    task automatic test_mid_reset();
        enq_amount_i = 4'd4;
        tick();
        enq_amount_i = 4'd0;
        n_cmp++; if (used_entries_r_o !== 4'd4 || wptr_r_o !== 3'd7) begin n_fail++; $display("FAIL mid_pre got u%0d w%0d want u4 w7", used_entries_r_o, wptr_r_o); end
        #2 reset_n_i = 1'b0;
        #1;
        n_cmp++; if (used_entries_r_o !== 4'd0 || free_entries_r_o !== 4'd8 || wptr_r_o !== 3'd0 || rptr_r_o !== 3'd0) begin n_fail++; $display("FAIL mid_reset_state got u%0d f%0d w%0d r%0d want 0 8 0 0", used_entries_r_o, free_entries_r_o, wptr_r_o, rptr_r_o); end
        n_cmp++; if ({empty_o, full_o, head_v_o} !== 3'b100 || valid_r_o !== 8'h00) begin n_fail++; $display("FAIL mid_reset_flags got %b %h want 100 00", {empty_o, full_o, head_v_o}, valid_r_o); end
        #1 reset_n_i = 1'b1;
    endtask

    task automatic test_back_to_back();
        enq_amount_i = 4'd8;
        tick();
        enq_amount_i = 4'd0;
        n_cmp++; if (wptr_r_o !== 3'd0 || used_entries_r_o !== 4'd8 || full_o !== 1'b1) begin n_fail++; $display("FAIL b2b_fill got w%0d u%0d f%b want w0 u8 f1", wptr_r_o, used_entries_r_o, full_o); end
        deq_amount_i = 1'b1;
        repeat (8) tick();
        deq_amount_i = 1'b0;
        n_cmp++; if (rptr_r_o !== 3'd0 || used_entries_r_o !== 4'd0 || free_entries_r_o !== 4'd8 || empty_o !== 1'b1) begin n_fail++; $display("FAIL b2b_drain got r%0d u%0d f%0d e%b want r0 u0 f8 e1", rptr_r_o, used_entries_r_o, free_entries_r_o, empty_o); end
    endtask

    initial begin
        test_reset();
        test_alloc_wrap();
        test_full_swap();
        test_collision();
        test_out_of_order();
        test_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
